// File: rtl/gate_exerciser.sv
// Self-test driver/checker: walks a gate's inputs through every combination and checks its output against TRUTH.
// Optional GATE_EXERCISER_SYNC_EN adds a two-flop synchronizer on x_in and stretches SETTLE by two cycles.
module gate_exerciser #(
  parameter int                          N_INPUTS      = 2,
  parameter logic [(2**N_INPUTS)-1:0]    TRUTH         = 4'b1000,
  parameter int                          SETTLE_CYCLES = 4,
  parameter int                          ERR_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     x_in,
  output logic [N_INPUTS-1:0]      a_out,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_W-1:0]         err_count,
  output logic [(2**N_INPUTS)-1:0] fail_vec
);

  localparam int NV = 2**N_INPUTS;
`ifdef GATE_EXERCISER_SYNC_EN
  localparam int CNT_LAST_I = SETTLE_CYCLES + 1;
`else
  localparam int CNT_LAST_I = SETTLE_CYCLES - 1;
`endif
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 2) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t               state, state_nxt;
  logic [N_INPUTS-1:0]  vec, vec_nxt, a_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 busy_nxt, done_nxt, pass_nxt;
  logic [ERR_W-1:0]     err_nxt;
  logic [NV-1:0]        fail_nxt;
  logic                 x_cmp;
  logic                 mismatch;

`ifdef GATE_EXERCISER_SYNC_EN
  logic [1:0] x_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) x_sync <= 2'b00;
    else        x_sync <= {x_sync[0], x_in};
  end

  assign x_cmp = x_sync[1];
`else
  assign x_cmp = x_in;
`endif

  assign mismatch = (x_cmp != TRUTH[vec]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= '0;
      cnt       <= '0;
      a_out     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      state     <= state_nxt;
      vec       <= vec_nxt;
      cnt       <= cnt_nxt;
      a_out     <= a_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_count <= err_nxt;
      fail_vec  <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    vec_nxt   = vec;
    cnt_nxt   = cnt;
    a_nxt     = a_out;
    busy_nxt  = busy;
    done_nxt  = done;
    pass_nxt  = pass;
    err_nxt   = err_count;
    fail_nxt  = fail_vec;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          vec_nxt   = '0;
          cnt_nxt   = '0;
          a_nxt     = '0;
          err_nxt   = '0;
          fail_nxt  = '0;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (mismatch) begin
          fail_nxt[vec] = 1'b1;
          if (err_count != '1) err_nxt = err_count + 1'b1;
        end
        if (vec == '1) begin
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          // fail_vec still holds earlier vectors only; fold in this edge's result.
          pass_nxt  = (fail_vec == '0) && !mismatch;
          state_nxt = DONE;
        end else begin
          vec_nxt   = vec + 1'b1;
          a_nxt     = vec + 1'b1;
          cnt_nxt   = '0;
          state_nxt = SETTLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench for gate_exerciser: two instances (AND truth table and a 4'b1110 truth table) driven by gate models.
// Expected run results come from a reference model and are queued at start, then popped when done rises.
module tb_gate_exerciser;

`ifdef GATE_EXERCISER_SYNC_EN
  localparam int HOLD = 4 + 3;
`else
  localparam int HOLD = 4 + 1;
`endif
  localparam int TOTAL = 4 * HOLD;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  bit         sel = 1'b0;
  int         x_model = 0;

  logic       x_in_a, x_in_b;
  logic [1:0] a_out_a, a_out_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [7:0] err_a, err_b;
  logic [3:0] fail_a, fail_b;

  gate_exerciser dut_a (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .x_in(x_in_a),
    .a_out(a_out_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .fail_vec(fail_a)
  );

  gate_exerciser #(.TRUTH(4'b1110)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .x_in(x_in_b),
    .a_out(a_out_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .fail_vec(fail_b)
  );

  // gate models: 0 = AND, 1 = stuck-at-0, 2 = OR
  function automatic logic gate_model(input int model, input logic [1:0] a);
    case (model)
      0:       return a[0] & a[1];
      1:       return 1'b0;
      default: return a[0] | a[1];
    endcase
  endfunction

  always_comb x_in_a = gate_model(x_model, a_out_a);
  always_comb x_in_b = gate_model(x_model, a_out_b);

  logic [1:0] s_a_out;
  logic       s_busy, s_done, s_pass;
  logic [7:0] s_err;
  logic [3:0] s_fail;
  always_comb begin
    s_a_out = sel ? a_out_b : a_out_a;
    s_busy  = sel ? busy_b  : busy_a;
    s_done  = sel ? done_b  : done_a;
    s_pass  = sel ? pass_b  : pass_a;
    s_err   = sel ? err_b   : err_a;
    s_fail  = sel ? fail_b  : fail_a;
  end

  // scoreboard: {fail_vec, err_count, pass}
  logic [12:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [12:0] exp_result(input int model, input logic [3:0] truth);
    logic [3:0] fv;
    logic [7:0] ec;
    logic       x;
    logic [1:0] av;
    fv = '0;
    ec = '0;
    for (int v = 0; v < 4; v++) begin
      av = 2'(v);
      x  = gate_model(model, av);
      if (x != truth[v]) begin
        fv[v] = 1'b1;
        ec    = ec + 8'd1;
      end
    end
    return {fv, ec, (fv == 4'b0000)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int model, input bit poke);
    bit seen;
    x_model = model;
    exp_q.push_back(exp_result(model, sel ? 4'b1110 : 4'b1000));
    start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 0; e < TOTAL; e++) begin
      check("a_out_step", 32'(s_a_out), 32'(e / HOLD));
      check("busy_done_pass_in_run", {s_busy, s_done, s_pass}, 3'b100);
      start = poke && (e == 3 || e == 10);
      step();
    end
    start = 1'b0;
    check("done_at_edge", {s_busy, s_done}, 2'b01);
    seen = s_done;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      seen = s_done;
    end
    check("done_timeout", 32'(seen), 32'd1);
    check("result", {s_fail, s_err, s_pass}, exp_q.pop_front());
    check("a_out_hold", 32'(s_a_out), 32'd3);
  endtask

  initial begin
    bit seen;
    // reset state, then release with start low
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {a_out_a, busy_a, done_a, pass_a, err_a, fail_a}, 17'd0);
    rst_n = 1'b1;
    repeat (3) step();
    check("post_release_idle", {a_out_a, busy_a, done_a, pass_a, err_a, fail_a}, 17'd0);

    run_vec(0, 1'b0);  // ideal AND
    run_vec(1, 1'b0);  // stuck-at-0
    run_vec(2, 1'b0);  // OR against AND truth table
    sel = 1'b1;
    run_vec(2, 1'b0);  // OR against 4'b1110
    sel = 1'b0;
    run_vec(0, 1'b1);  // start pokes mid-run are ignored

    // start in DONE restarts on the next edge; done lasts a single cycle
    start = 1'b1;
    step();
    check("restart_from_done", {s_busy, s_done, s_pass, s_a_out}, 5'b10000);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < TOTAL && !seen; i++) begin
      step();
      seen = (s_a_out == 2'd2);
    end
    check("reach_vec2", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_midrun", {a_out_a, busy_a, done_a, pass_a, err_a, fail_a}, 17'd0);
    step();
    rst_n = 1'b1;
    step();
    run_vec(0, 1'b0);  // full run after reset

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gate_exerciser.md
Name: gate_exerciser

Overview:
Self-test driver/checker for the team's small combinational gate modules on the board. It drives a gate's inputs through every input combination and waits a programmable settle time. It then samples the gate output and checks it against a truth-table parameter, reporting a per-vector fail map, an error count and a pass flag. It sits on the driving side of the gate under test: a_out feeds the gate inputs and x_in takes the gate output.

Parameters:
N_INPUTS, 2, number of gate inputs driven (1..8)
TRUTH, 4'b1000, expected output per vector; bit i = expected x for a_out==i; width 2**N_INPUTS; default is AND
SETTLE_CYCLES, 4, clock cycles a vector is held before sampling (>=1)
ERR_W, 8, width of the error counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  start a run; sampled in IDLE or DONE only
x_in  input  1  output of gate under test
a_out  output  N_INPUTS  vector driven to gate inputs
busy  output  1  high while a run is in progress
done  output  1  high from run completion until next start or reset
pass  output  1  high when done and err_count==0
err_count  output  ERR_W  number of mismatching vectors, saturating
fail_vec  output  2**N_INPUTS  bit i set if vector i mismatched

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low on rst_n; all state is cleared immediately on assertion.
- Reset values: state=IDLE, a_out=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, internal vector and settle counters=0.
- FSM states are IDLE, SETTLE, SAMPLE, DONE.
- IDLE or DONE with start=1 at an edge:
  - a_out<=0, vec<=0, cnt<=0
  - err_count<=0, fail_vec<=0, done<=0, pass<=0, busy<=1
  - go to SETTLE
- SETTLE: cnt increments each edge. At the edge where cnt==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE: compare x_in with TRUTH[vec] at this edge.
  - On mismatch: fail_vec[vec]<=1, and err_count<=err_count+1 unless it is already all-ones (saturate).
  - If vec==2**N_INPUTS-1: busy<=0, done<=1, pass<=(no mismatch over the whole run, including this edge); go to DONE.
  - Otherwise: vec<=vec+1, a_out<=vec+1, cnt<=0; go to SETTLE.
- Timing: each vector is held SETTLE_CYCLES+1 cycles. done rises (2**N_INPUTS)*(SETTLE_CYCLES+1) edges after the start edge. With defaults that is 20 edges.
- a_out holds the last vector in DONE. It returns to 0 only on a new start or reset.
- start while busy (SETTLE/SAMPLE) is ignored; the run continues unaffected.
- start held high continuously in DONE: a new run begins the edge after DONE is entered. done is high for exactly one cycle in that case.
- Reset mid-run: everything returns to reset values asynchronously. No partial results are retained.
- pass is only meaningful with done=1; it is forced 0 whenever done=0.
- x_in is sampled only in SAMPLE; its value in other states has no effect.

Optional Feature:
GATE_EXERCISER_SYNC_EN
- Defined:
  - x_in passes through a two-flop synchronizer (reset to 0) before comparison, for off-board or asynchronous gates.
  - The SETTLE phase is extended by 2 cycles, so cnt terminates at SETTLE_CYCLES+1.
  - Each vector is held SETTLE_CYCLES+3 cycles; the default run completes in 28 edges.
- Undefined: x_in is compared directly, with timing as above.

Test Plan:
1. Hold rst_n=0, toggle clk: a_out=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0. Release reset with start=0: outputs stay unchanged.
2. Ideal AND model on a_out->x_in, one-cycle start pulse:
   - a_out steps 0,1,2,3, each held 5 cycles; busy high for 20 cycles.
   - done=1 at edge 20; pass=1, err_count=0, fail_vec=4'b0000.
3. x_in tied to 0 (stuck-at-0), default params -> fail_vec=4'b1000, err_count=1, pass=0, done=1.
4. OR model connected, default TRUTH -> fail_vec=4'b0110, err_count=2, pass=0. Repeat with TRUTH=4'b1110 -> pass=1.
5. Start pulses at cycles 3 and 10 of a run -> run completes at edge 20 unchanged. Assert rst_n=0 while a_out==2 -> immediate reset values. Restart -> full 20-cycle run, results correct.
6. GATE_EXERCISER_SYNC_EN defined, AND model, SETTLE_CYCLES=4 -> each vector held 7 cycles, done at edge 28, pass=1. Same bench with x_in stuck-at-0 -> fail_vec=4'b1000.
